// File: rtl/ascii_text_writer.sv
// ascii_text_writer: takes ASCII codes over a valid/ready handshake and places
// them in the VGA character RAM at a managed cursor. It handles line wrap,
// ENTER (0x00) newlines, row wrap-around with clearing of the new line, and a
// full-screen clear after reset or on CLR.
module ascii_text_writer #(
  parameter int P_COLS       = 40,
  parameter int P_ROWS       = 15,
  parameter int P_COL_WIDTH  = 6,
  parameter int P_ROW_WIDTH  = 4,
  parameter int P_ADDR_WIDTH = 10
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [7:0]              ASCII_CODE,
  input  logic                    ASCII_VALID,
  output logic                    ASCII_READY,
  input  logic                    CLR,
  output logic                    VRAM_WE,
  output logic [P_ADDR_WIDTH-1:0] VRAM_ADDR,
  output logic [7:0]              VRAM_DATA,
  output logic [P_COL_WIDTH-1:0]  CURSOR_COL,
  output logic [P_ROW_WIDTH-1:0]  CURSOR_ROW,
  output logic                    ERR
);

  localparam logic [7:0]              L_SPACE     = 8'h20;
  localparam logic [7:0]              L_ENTER     = 8'h00;
  localparam logic [P_ADDR_WIDTH-1:0] L_LAST_CELL = P_ADDR_WIDTH'(P_COLS * P_ROWS - 1);
  localparam logic [P_ADDR_WIDTH-1:0] L_LAST_LCNT = P_ADDR_WIDTH'(P_COLS - 1);
  localparam logic [P_COL_WIDTH-1:0]  L_LAST_COL  = P_COL_WIDTH'(P_COLS - 1);
  localparam logic [P_ROW_WIDTH-1:0]  L_LAST_ROW  = P_ROW_WIDTH'(P_ROWS - 1);
  localparam logic [P_ADDR_WIDTH-1:0] L_COLS_A    = P_ADDR_WIDTH'(P_COLS);

  // S_WRITE is the one-cycle recovery slot after any accepted code that does
  // not start a line clear (printable write or rejected code).
  typedef enum logic [1:0] {
    S_CLR_ALL  = 2'd0,
    S_IDLE     = 2'd1,
    S_WRITE    = 2'd2,
    S_LINE_CLR = 2'd3
  } state_t;

  state_t                  r_state;
  logic [P_ADDR_WIDTH-1:0] r_cnt;    // clear address (screen) or column (line)
  logic [P_COL_WIDTH-1:0]  r_col;
  logic [P_ROW_WIDTH-1:0]  r_row;
  logic                    r_ready;
  logic                    r_we;
  logic [P_ADDR_WIDTH-1:0] r_addr;
  logic [7:0]              r_data;
  logic                    r_err;

  logic [P_ADDR_WIDTH-1:0] w_row_base;
  logic [P_ADDR_WIDTH-1:0] w_cur_addr;
  logic [P_ADDR_WIDTH-1:0] w_line_addr;
  logic [P_ROW_WIDTH-1:0]  w_next_row;
  logic                    w_accept;
  logic                    w_is_enter;
  logic                    w_printable;

  // Cursor row base address; the cursor row is already the new row during a
  // line clear, so the same base serves both character writes and clears.
  assign w_row_base  = P_ADDR_WIDTH'(r_row) * L_COLS_A;
  assign w_cur_addr  = w_row_base + P_ADDR_WIDTH'(r_col);
  assign w_line_addr = w_row_base + r_cnt;
  assign w_next_row  = (r_row == L_LAST_ROW) ? '0 : r_row + 1'b1;

  // READY is the registered output, so accept matches what the producer sees.
  assign w_accept    = ASCII_VALID & r_ready & ~CLR;
  assign w_is_enter  = (ASCII_CODE == L_ENTER);
  // An X/Z code fails both tests and falls through to the error branch.
  assign w_printable = (ASCII_CODE >= 8'h20) && (ASCII_CODE <= 8'h7E);

  // Main FSM: cursor, clear counters and all registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_CLR_ALL;
      r_cnt   <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= L_SPACE;
      r_err   <= 1'b0;
    end else if (CLR) begin
      // Abandon whatever is in flight and restart the full clear from 0.
      r_state <= S_CLR_ALL;
      r_cnt   <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we  <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_CLR_ALL: begin
          r_we    <= 1'b1;
          r_addr  <= r_cnt;
          r_data  <= L_SPACE;
          r_ready <= 1'b0;
          if (r_cnt == L_LAST_CELL) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_IDLE: begin
          // First IDLE cycle after a clear only raises READY.
          r_ready <= 1'b1;
          if (w_accept) begin
            r_ready <= 1'b0;
            if (w_is_enter) begin
              r_col   <= '0;
              r_row   <= w_next_row;
              r_cnt   <= '0;
              r_state <= S_LINE_CLR;
            end else if (w_printable) begin
              r_we   <= 1'b1;
              r_addr <= w_cur_addr;
              r_data <= ASCII_CODE;
              if (r_col == L_LAST_COL) begin
                r_col   <= '0;
                r_row   <= w_next_row;
                r_cnt   <= '0;
                r_state <= S_LINE_CLR;
              end else begin
                r_col   <= r_col + 1'b1;
                r_state <= S_WRITE;
              end
            end else begin
              r_err   <= 1'b1;
              r_state <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end

        S_LINE_CLR: begin
          r_we   <= 1'b1;
          r_addr <= w_line_addr;
          r_data <= L_SPACE;
          if (r_cnt == L_LAST_LCNT) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_cnt   <= '0;
          r_state <= S_CLR_ALL;
        end
      endcase
    end
  end

  assign ASCII_READY = r_ready;
  assign VRAM_WE     = r_we;
  assign VRAM_ADDR   = r_addr;
  assign VRAM_DATA   = r_data;
  assign CURSOR_COL  = r_col;
  assign CURSOR_ROW  = r_row;
  assign ERR         = r_err;

endmodule

// File: tb/tb_ascii_text_writer.sv
// tb_ascii_text_writer: directed bench for ascii_text_writer at the default
// 40x15 geometry. Expected addresses and cursor positions are hand-derived.
module tb_ascii_text_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] code;
  logic       valid;
  logic       ready;
  logic       clr;
  logic       we;
  logic [9:0] addr;
  logic [7:0] data;
  logic [5:0] ccol;
  logic [3:0] crow;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  ascii_text_writer dut (
    .CLK         (clk),
    .RESET       (rst),
    .ASCII_CODE  (code),
    .ASCII_VALID (valid),
    .ASCII_READY (ready),
    .CLR         (clr),
    .VRAM_WE     (we),
    .VRAM_ADDR   (addr),
    .VRAM_DATA   (data),
    .CURSOR_COL  (ccol),
    .CURSOR_ROW  (crow),
    .ERR         (err)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {WE, ADDR, DATA} packed for compact write checks.
  function automatic logic [31:0] wr(input logic w, input int a, input logic [7:0] d);
    return {13'd0, w, 10'(a), d};
  endfunction

  // Full-screen clear: 600 consecutive space writes, then READY with no write.
  task automatic clear_wait(input string tag);
    for (int i = 0; i < 600; i++) begin
      tick();
      chk({tag, "_wr"}, {13'd0, we, addr, data}, wr(1'b1, i, 8'h20));
    end
    tick();
    chk({tag, "_rdy"}, {30'd0, we, ready}, 32'h1);
    $display("[TB] %s: full clear observed", tag);
  endtask

  // Line clear of row r after the newline has been accepted.
  task automatic line_wait(input string tag, input int r);
    for (int j = 0; j < 40; j++) begin
      tick();
      chk({tag, "_lclr"}, {13'd0, we, addr, data}, wr(1'b1, r * 40 + j, 8'h20));
    end
    tick();
    chk({tag, "_rdy"}, {30'd0, we, ready}, 32'h1);
  endtask

  // Printable char not at the last column: write, then READY back after 1 cycle.
  task automatic send_print(input string tag, input logic [7:0] c, input int a,
                            input int col_after, input int row_after);
    code  = c;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    chk({tag, "_wr"}, {13'd0, we, addr, data}, wr(1'b1, a, c));
    chk({tag, "_cur"}, {22'd0, ccol, crow}, {22'd0, 6'(col_after), 4'(row_after)});
    chk({tag, "_rdylo"}, {31'd0, ready}, 32'h0);
    tick();
    chk({tag, "_rdyhi"}, {30'd0, we, ready}, 32'h1);
    $display("[TB] %s: code 0x%02h -> addr %0d, cursor (%0d,%0d)", tag, c, a, col_after, row_after);
  endtask

  task automatic send_enter(input string tag, input int new_row);
    code  = 8'h00;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    chk({tag, "_nowr"}, {31'd0, we}, 32'h0);
    chk({tag, "_cur"}, {22'd0, ccol, crow}, {22'd0, 6'd0, 4'(new_row)});
    line_wait(tag, new_row);
    $display("[TB] %s: ENTER -> row %0d cleared", tag, new_row);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; valid = 1'b0; code = 8'h00;

    // 1. Reset values, then the power-up full clear.
    tick();
    chk("rst_outs", {13'd0, we, addr, data}, wr(1'b0, 0, 8'h20));
    chk("rst_ctl", {20'd0, ready, err, ccol, crow}, 32'h0);
    rst = 1'b0;
    clear_wait("t1_pwrup");

    // 2. Single printable character.
    send_print("t2_A", 8'h41, 0, 1, 0);

    // 3. Fill row 0 from column 0; the 40th char wraps and clears row 1.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t3_clr_cur", {20'd0, ready, err, ccol, crow}, 32'h0);
    clear_wait("t3_clr");
    for (int i = 0; i < 39; i++) send_print("t3_B", 8'h42, i, i + 1, 0);
    code  = 8'h42;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("t3_last_wr", {13'd0, we, addr, data}, wr(1'b1, 39, 8'h42));
    chk("t3_wrap_cur", {22'd0, ccol, crow}, {22'd0, 6'd0, 4'd1});
    line_wait("t3_wrap", 1);
    $display("[TB] t3: row 0 filled, wrapped to (0,1)");

    // 4. Walk to row 14, move to column 5, ENTER wraps to row 0 and clears it.
    for (int r = 2; r < 15; r++) send_enter("t4_nl", r);
    for (int i = 0; i < 5; i++) send_print("t4_C", 8'h43, 560 + i, i + 1, 14);
    send_enter("t4_wrap", 0);

    // 5. CLR in the middle of the row-3 line clear restarts the full clear.
    send_enter("t5_nl", 1);
    send_enter("t5_nl", 2);
    code  = 8'h00;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("t5_cur3", {22'd0, ccol, crow}, {22'd0, 6'd0, 4'd3});
    for (int j = 0; j < 10; j++) begin
      tick();
      chk("t5_lclr", {13'd0, we, addr, data}, wr(1'b1, 120 + j, 8'h20));
    end
    clr   = 1'b1;
    code  = 8'h41;
    valid = 1'b1;
    tick();
    clr   = 1'b0;
    valid = 1'b0;
    chk("t5_abort", {13'd0, we, ready, err, ccol, crow}, 32'h0);
    clear_wait("t5_restart");

    // 6. Non-printable code pulses ERR without a write, then 0x31 is written.
    code  = 8'h07;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("t6_err", {29'd0, err, we, ready}, 32'h4);
    chk("t6_cur", {22'd0, ccol, crow}, 32'h0);
    $display("[TB] t6: code 0x07 rejected, err=%0b", err);
    tick();
    chk("t6_err_end", {29'd0, err, we, ready}, 32'h1);
    send_print("t6_1", 8'h31, 0, 1, 0);

    // 7. RESET in the middle of a full clear behaves as power-up.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int j = 0; j < 5; j++) tick();
    chk("t7_midclr", {13'd0, we, addr, data}, wr(1'b1, 4, 8'h20));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_rst_outs", {13'd0, we, addr, data}, wr(1'b0, 0, 8'h20));
    chk("t7_rst_ctl", {20'd0, ready, err, ccol, crow}, 32'h0);
    clear_wait("t7_reclr");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
